// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment display scan controller.
package disp_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam logic [7:0]  ANI_OFF    = 8'hFF;
   localparam logic [3:0]  BCD_BLANK  = 4'hF;

   typedef enum logic [1:0] {GUARD, ON, OFF} scan_state_t;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Bus between the stopwatch digit source, the scan controller and the segment decoder.
// Optional blink_mask field exists only when DISP_BLINK_EN is defined.
interface disp_scan_ctrl_if;
   import disp_pkg::*;

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    lz_blank_en;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [1:0]              brightness;
`ifdef DISP_BLINK_EN
   logic [NUM_DIGITS-1:0]   blink_mask;
`endif
   logic [NUM_DIGITS-1:0]   ani;
   logic [3:0]              bcd_val;
   logic                    dp_n;
   logic [2:0]              digit_sel;
   logic                    frame_start;

   modport master (
      output digits_in, lz_blank_en, dp_mask, brightness,
`ifdef DISP_BLINK_EN
      output blink_mask,
`endif
      input  ani, bcd_val, dp_n, digit_sel, frame_start
   );

   modport slave (
      input  digits_in, lz_blank_en, dp_mask, brightness,
`ifdef DISP_BLINK_EN
      input  blink_mask,
`endif
      output ani, bcd_val, dp_n, digit_sel, frame_start
   );

endinterface

// File: rtl/lz_blank_mask.sv
// Leading-zero blank mask: digit i (i >= 1) is blanked when it and every digit above it are zero.
module lz_blank_mask
   import disp_pkg::*;
(
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic                    en,
   output logic [NUM_DIGITS-1:0]   blank
);

   logic zero_above;

   // Walk from the most significant digit down; digit 0 is never blanked.
   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (digits[4*i +: 4] == 4'd0);
         blank[i]   = en & zero_above;
      end
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan controller with dead-time guard, duty dimming,
// leading-zero blanking and decimal points. Optional blinking when DISP_BLINK_EN is defined.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 12500,
   parameter int unsigned GUARD_CYCLES = 16
`ifdef DISP_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES = 250
`endif
) (
   input logic              clk,
   input logic              rst,
   disp_scan_ctrl_if.slave  bus
);

   localparam int unsigned      CNT_W     = $clog2(SCAN_DIV);
   localparam int unsigned      ON_CYCLES = SCAN_DIV - GUARD_CYCLES;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0]        cnt_q;
   logic [2:0]              sel_q;
   logic [4*NUM_DIGITS-1:0] digits_q;
   logic                    lz_en_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [1:0]              bright_q;
   logic [NUM_DIGITS-1:0]   ani_q;
   logic [3:0]              bcd_q;
   logic                    dp_n_q;

   logic [NUM_DIGITS-1:0]   blank;
   logic [NUM_DIGITS-1:0]   sel_onehot;
   logic                    frame_tick;
   logic                    dark;
   logic [31:0]             on_len;
   logic [31:0]             cnt_ext;
   scan_state_t             state;

   // Gated by rst so the pulse shows on the first cycle after reset is released, not during it.
   assign frame_tick = (cnt_q == '0) && (sel_q == 3'd0) && !rst;
   assign sel_onehot = 8'd1 << sel_q;

   always_comb begin
      on_len  = ON_CYCLES >> (2'd3 - bright_q);
      cnt_ext = 32'(cnt_q);
      if (cnt_ext < GUARD_CYCLES) begin
         state = GUARD;
      end else if (cnt_ext < GUARD_CYCLES + on_len) begin
         state = ON;
      end else begin
         state = OFF;
      end
   end

   lz_blank_mask u_lz_blank_mask (
      .digits (digits_q),
      .en     (lz_en_q),
      .blank  (blank)
   );

`ifdef DISP_BLINK_EN
   localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FR_W-1:0]       frame_cnt_q;
   logic                  phase_q;
   logic [NUM_DIGITS-1:0] blink_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         phase_q     <= 1'b0;
         blink_q     <= '0;
      end else if (frame_tick) begin
         blink_q <= bus.blink_mask;
         if (frame_cnt_q == FR_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign dark = phase_q & blink_q[sel_q];
`else
   assign dark = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         sel_q    <= '0;
         digits_q <= '0;
         lz_en_q  <= 1'b0;
         dp_q     <= '0;
         bright_q <= 2'd3;
         ani_q    <= ANI_OFF;
         bcd_q    <= '0;
         dp_n_q   <= 1'b1;
      end else begin
         if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            sel_q <= sel_q + 3'd1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end

         // Inputs are frozen for the whole frame so a mid-frame update cannot tear.
         if (frame_tick) begin
            digits_q <= bus.digits_in;
            lz_en_q  <= bus.lz_blank_en;
            dp_q     <= bus.dp_mask;
            bright_q <= bus.brightness;
         end

         ani_q  <= ANI_OFF;
         dp_n_q <= 1'b1;
         if (state == ON && !dark) begin
            if (blank[sel_q]) begin
               bcd_q <= BCD_BLANK;
               // A blanked digit still lights its anode when only the decimal point is wanted.
               if (dp_q[sel_q]) begin
                  ani_q  <= ~sel_onehot;
                  dp_n_q <= 1'b0;
               end
            end else begin
               ani_q  <= ~sel_onehot;
               bcd_q  <= digits_q[{sel_q, 2'b00} +: 4];
               dp_n_q <= ~dp_q[sel_q];
            end
         end
      end
   end

   assign bus.ani         = ani_q;
   assign bus.bcd_val     = bcd_q;
   assign bus.dp_n        = dp_n_q;
   assign bus.digit_sel   = sel_q;
   assign bus.frame_start = frame_tick;

endmodule
